axi_lite_sram: RTL and testbench

AXI-lite responder backed by a word-addressed on-chip memory array. It serves the load/store unit's read (AR/R) and write (AW/W/B) requests as the slave end of the data-memory bus. Read and write channels run independent state machines with a programmable response latency. This gives the core a self-contained data memory for simulation and FPGA bring-up.

---
 rtl/axi_lite_sram_pkg.sv | 24 ++
 rtl/axi_lite_sram_if.sv | 32 +++
 rtl/axi_lite_sram_lat_gen.sv | 38 +++
 rtl/axi_lite_sram.sv | 233 +++++++++++++++++++++++
 tb/tb_axi_lite_sram.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_lite_sram_pkg.sv
// Shared types and constants for the AXI-lite SRAM responder.
// Response codes, read/write state encodings and the latency LFSR seed.
// Imported by the latency source and by the top level.
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_WAIT = 2'd1,
      R_RESP = 2'd2
   } r_state_e;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_WAIT = 2'd1,
      W_RESP = 2'd2
   } w_state_e;

   localparam logic [3:0] LFSR_SEED = 4'b1001;

endpackage

// File: rtl/axi_lite_sram_if.sv
// AXI-lite data-memory bus between the load/store unit and the SRAM.
// Pure wiring: no state and no latency of its own.
// Flow control is the standard valid/ready pair on each channel.
interface axi_lite_sram_if;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [7:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );

   modport slave (
      input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/axi_lite_sram_lat_gen.sv
// Response latency source shared by the read and write FSMs.
// Output is a registered LFSR value (AXI_SRAM_RAND_DELAY_EN) or the constant LATENCY.
// No backpressure: the value is sampled whenever an FSM accepts a request.
module axi_lat_gen
   import axi_lite_pkg::*;
#(
   parameter int LATENCY = 1
) (
   input  logic       clk,
   input  logic       rst,
   output logic [3:0] lat
);

`ifdef AXI_SRAM_RAND_DELAY_EN
   localparam int unused_latency = LATENCY;

   logic [3:0] lfsr_q;
   logic [3:0] lfsr_d;

   // x^4+x^3+1 Fibonacci step, free-running every cycle
   always_comb begin
      lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
   end

   // LFSR register, reseeded on reset
   always_ff @(posedge clk) begin
      if (rst) lfsr_q <= LFSR_SEED;
      else     lfsr_q <= lfsr_d;
   end

   assign lat = lfsr_q;
`else
   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ rst;
   assign lat = 4'(LATENCY);
`endif

endmodule

// File: rtl/axi_lite_sram.sv
// AXI-lite slave backed by a word-addressed SRAM; optional AXI_SRAM_RAND_DELAY_EN randomizes latency.
// Latency: response valid LATENCY+1 edges after request acceptance (AR, or the later of AW/W).
// Backpressure: one outstanding request per channel; readys stay low until the response is taken.
module axi_lite_sram
   import axi_lite_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter int          DEPTH     = 4096,
   parameter int          LATENCY   = 1,
   parameter string       INIT_FILE = ""
) (
   input  logic            clk,
   input  logic            rst,
   axi_lite_sram_if.slave  bus
);

   localparam int          IDX_W = $clog2(DEPTH);
   localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;

   function automatic logic in_range(input logic [31:0] addr);
      return (addr >= BASE_ADDR) && ({1'b0, addr - BASE_ADDR} < SPAN);
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
      return IDX_W'((addr - BASE_ADDR) >> 2);
   endfunction

   logic [31:0] mem_q [DEPTH];

   logic [3:0] lat;

   axi_lat_gen #(.LATENCY(LATENCY)) u_lat_gen (
      .clk (clk),
      .rst (rst),
      .lat (lat)
   );

   logic unused_wstrb_hi;
   assign unused_wstrb_hi = ^bus.wstrb[7:4];

   // ---------------- read channel ----------------
   r_state_e    r_state_q, r_state_d;
   logic [31:0] ar_addr_q, ar_addr_d;
   logic [3:0]  r_cnt_q, r_cnt_d;
   logic        arready_q, arready_d;
   logic        rvalid_q, rvalid_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  rresp_q, rresp_d;

   // read FSM next state: accept, count down, then hold the response until taken
   always_comb begin
      r_state_d = r_state_q;
      ar_addr_d = ar_addr_q;
      r_cnt_d   = r_cnt_q;
      arready_d = arready_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      case (r_state_q)
         R_IDLE: begin
            arready_d = 1'b1;
            if (bus.arvalid && arready_q) begin
               ar_addr_d = bus.araddr;
               arready_d = 1'b0;
               r_cnt_d   = lat;
               r_state_d = R_WAIT;
            end
         end
         R_WAIT: begin
            if (r_cnt_q == 4'd0) begin
               if (in_range(ar_addr_q)) begin
                  rdata_d = mem_q[word_idx(ar_addr_q)];
                  rresp_d = RESP_OKAY;
               end else begin
                  rdata_d = 32'h0;
                  rresp_d = RESP_DECERR;
               end
               rvalid_d  = 1'b1;
               r_state_d = R_RESP;
            end else begin
               r_cnt_d = r_cnt_q - 4'd1;
            end
         end
         R_RESP: begin
            if (bus.rready) begin
               rvalid_d  = 1'b0;
               arready_d = 1'b1;
               r_state_d = R_IDLE;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // read FSM registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state_q <= R_IDLE;
         ar_addr_q <= 32'h0;
         r_cnt_q   <= 4'd0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= 32'h0;
         rresp_q   <= RESP_OKAY;
      end else begin
         r_state_q <= r_state_d;
         ar_addr_q <= ar_addr_d;
         r_cnt_q   <= r_cnt_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   // ---------------- write channel ----------------
   w_state_e    w_state_q, w_state_d;
   logic [31:0] aw_addr_q, aw_addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic        aw_got_q, aw_got_d;
   logic        w_got_q, w_got_d;
   logic [3:0]  w_cnt_q, w_cnt_d;
   logic        awready_q, awready_d;
   logic        wready_q, wready_d;
   logic        bvalid_q, bvalid_d;
   logic [1:0]  bresp_q, bresp_d;
   logic        mem_we;

   // write FSM next state: collect AW and W in any order, count down, commit, respond
   always_comb begin
      w_state_d = w_state_q;
      aw_addr_d = aw_addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      aw_got_d  = aw_got_q;
      w_got_d   = w_got_q;
      w_cnt_d   = w_cnt_q;
      awready_d = awready_q;
      wready_d  = wready_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      mem_we    = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            if (bus.awvalid && awready_q) begin
               aw_addr_d = bus.awaddr;
               aw_got_d  = 1'b1;
            end
            if (bus.wvalid && wready_q) begin
               wdata_d = bus.wdata;
               wstrb_d = bus.wstrb[3:0];
               w_got_d = 1'b1;
            end
            awready_d = !aw_got_d;
            wready_d  = !w_got_d;
            if (aw_got_d && w_got_d) begin
               w_cnt_d   = lat;
               w_state_d = W_WAIT;
            end
         end
         W_WAIT: begin
            if (w_cnt_q == 4'd0) begin
               mem_we    = in_range(aw_addr_q);
               bresp_d   = in_range(aw_addr_q) ? RESP_OKAY : RESP_DECERR;
               bvalid_d  = 1'b1;
               w_state_d = W_RESP;
            end else begin
               w_cnt_d = w_cnt_q - 4'd1;
            end
         end
         W_RESP: begin
            if (bus.bready) begin
               bvalid_d  = 1'b0;
               awready_d = 1'b1;
               wready_d  = 1'b1;
               aw_got_d  = 1'b0;
               w_got_d   = 1'b0;
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // write FSM registers
   always_ff @(posedge clk) begin
      if (rst) begin
         w_state_q <= W_IDLE;
         aw_addr_q <= 32'h0;
         wdata_q   <= 32'h0;
         wstrb_q   <= 4'h0;
         aw_got_q  <= 1'b0;
         w_got_q   <= 1'b0;
         w_cnt_q   <= 4'd0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
      end else begin
         w_state_q <= w_state_d;
         aw_addr_q <= aw_addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         aw_got_q  <= aw_got_d;
         w_got_q   <= w_got_d;
         w_cnt_q   <= w_cnt_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
      end
   end

   // byte-masked array commit; not reset so contents survive rst
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb_q[b]) mem_q[word_idx(aw_addr_q)][8*b +: 8] <= wdata_q[8*b +: 8];
         end
      end
   end

   assign bus.arready = arready_q;
   assign bus.rvalid  = rvalid_q;
   assign bus.rdata   = rdata_q;
   assign bus.rresp   = rresp_q;
   assign bus.awready = awready_q;
   assign bus.wready  = wready_q;
   assign bus.bvalid  = bvalid_q;
   assign bus.bresp   = bresp_q;

endmodule

// File: tb/tb_axi_lite_sram.sv
// Self-checking bench for axi_lite_sram: directed cases plus a randomized mix.
// Expected data comes from a sparse word model of the memory and the address map.
// Every handshake wait is bounded so the run always reaches its summary line.
module tb_axi_lite_sram;

   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int          DEPTH = 4096;
   localparam int          LAT   = 1;
   localparam int          LIMIT = 200;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   axi_lite_sram_if bus ();

   axi_lite_sram #(
      .BASE_ADDR (BASE),
      .DEPTH     (DEPTH),
      .LATENCY   (LAT),
      .INIT_FILE ("")
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;
   logic [31:0] model [int];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
      end
   endtask

   function automatic bit in_rng(input logic [31:0] addr);
      longint a;
      a = longint'(addr);
      return (a >= longint'(BASE)) && (a < longint'(BASE) + 4 * DEPTH);
   endfunction

   function automatic int widx(input logic [31:0] addr);
      return int'((addr - BASE) / 4);
   endfunction

   task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
      int n;
      int k;
      bus.araddr  = addr;
      bus.arvalid = 1'b1;
      bus.rready  = 1'b1;
      n = 0;
      while (!bus.arready && n < LIMIT) begin step(); n++; end
      check("ar_ready_seen", 32'(n < LIMIT), 32'd1);
      step();
      bus.arvalid = 1'b0;
      k = 0;
      while (!bus.rvalid && k < LIMIT) begin step(); k++; end
      check("r_latency", 32'(k), 32'(LAT + 1));
      data = bus.rdata;
      resp = bus.rresp;
      step();
      bus.rready = 1'b0;
      check("r_done_rvalid", 32'(bus.rvalid), 32'd0);
      check("r_done_arready", 32'(bus.arready), 32'd1);
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [7:0] strb,
                           input int wdelay, input bit chk_wait, output logic [1:0] resp);
      int cyc;
      int k;
      bit aw_done, w_done, aw_f, w_f;
      bus.awaddr  = addr;
      bus.awvalid = 1'b1;
      bus.wdata   = data;
      bus.wstrb   = strb;
      bus.wvalid  = 1'b0;
      bus.bready  = 1'b1;
      cyc = 0;
      aw_done = 1'b0;
      w_done  = 1'b0;
      while (!(aw_done && w_done) && cyc < LIMIT) begin
         if (cyc >= wdelay && !w_done) bus.wvalid = 1'b1;
         aw_f = bus.awvalid && bus.awready;
         w_f  = bus.wvalid && bus.wready;
         step();
         cyc++;
         if (aw_f) begin aw_done = 1'b1; bus.awvalid = 1'b0; end
         if (w_f)  begin w_done  = 1'b1; bus.wvalid  = 1'b0; end
         if (chk_wait && aw_done && !w_done) begin
            check("aw_only_awready", 32'(bus.awready), 32'd0);
            check("aw_only_wready", 32'(bus.wready), 32'd1);
            check("aw_only_bvalid", 32'(bus.bvalid), 32'd0);
         end
      end
      check("wr_handshakes", 32'(aw_done && w_done), 32'd1);
      k = 0;
      while (!bus.bvalid && k < LIMIT) begin step(); k++; end
      check("b_latency", 32'(k), 32'(LAT + 1));
      resp = bus.bresp;
      step();
      bus.bready = 1'b0;
      check("b_done_bvalid", 32'(bus.bvalid), 32'd0);
      check("b_done_readys", 32'({bus.awready, bus.wready}), 32'd3);
   endtask

   task automatic read_expect(input string tag, input logic [31:0] addr);
      logic [31:0] d;
      logic [1:0]  r;
      do_read(addr, d, r);
      if (in_rng(addr)) begin
         check({tag, "_rresp"}, 32'(r), 32'd0);
         check({tag, "_rdata"}, d, model[widx(addr)]);
      end else begin
         check({tag, "_rresp"}, 32'(r), 32'd3);
         check({tag, "_rdata"}, d, 32'd0);
      end
   endtask

   task automatic write_expect(input string tag, input logic [31:0] addr, input logic [31:0] data,
                               input logic [7:0] strb, input int wdelay, input bit chk_wait);
      logic [1:0]  r;
      logic [31:0] w;
      do_write(addr, data, strb, wdelay, chk_wait, r);
      if (in_rng(addr)) begin
         check({tag, "_bresp"}, 32'(r), 32'd0);
         w = model.exists(widx(addr)) ? model[widx(addr)] : 32'h0;
         for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = data[8*b +: 8];
         model[widx(addr)] = w;
      end else begin
         check({tag, "_bresp"}, 32'(r), 32'd3);
      end
   endtask

   initial begin
      logic [31:0] a_addr, b_addr, old_val, new_val, p, addr, oaddr, held;
      logic [31:0] pool [8];
      logic [7:0]  strb;
      int          k;
      int unsigned sel;

      bus.araddr = 32'h0; bus.arvalid = 1'b0; bus.rready = 1'b0;
      bus.awaddr = 32'h0; bus.awvalid = 1'b0; bus.wdata = 32'h0;
      bus.wstrb  = 8'h0;  bus.wvalid  = 1'b0; bus.bready = 1'b0;

      // reset state
      repeat (3) step();
      check("rst_arready", 32'(bus.arready), 32'd0);
      check("rst_awready", 32'(bus.awready), 32'd0);
      check("rst_wready", 32'(bus.wready), 32'd0);
      check("rst_rvalid", 32'(bus.rvalid), 32'd0);
      check("rst_bvalid", 32'(bus.bvalid), 32'd0);
      check("rst_rdata", bus.rdata, 32'd0);
      check("rst_resps", 32'({bus.rresp, bus.bresp}), 32'd0);
      rst = 1'b0;
      step();
      check("post_rst_readys", 32'({bus.arready, bus.awready, bus.wready}), 32'd7);

      // basic write/read, partial strobe
      write_expect("w_beef", 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 0, 1'b0);
      read_expect("r_beef", 32'h8000_0010);
      check("r_beef_const", model[4], 32'hDEAD_BEEF);
      write_expect("w_ab", 32'h8000_0010, 32'h0000_AB00, 8'h02, 0, 1'b0);
      read_expect("r_ab", 32'h8000_0010);
      check("r_ab_const", model[4], 32'hDEAD_ABEF);

      // decode errors and boundaries
      write_expect("w_w0", 32'h8000_0000, 32'h1234_5678, 8'hFF, 0, 1'b0);
      write_expect("w_last", 32'h8000_3FFC, 32'hCAFE_F00D, 8'h0F, 0, 1'b0);
      read_expect("r_oob0", 32'h0000_0000);
      write_expect("w_oob9", 32'h9000_0000, 32'hFFFF_FFFF, 8'h0F, 0, 1'b0);
      write_expect("w_oob_end", 32'h8000_4000, 32'hFFFF_FFFF, 8'h0F, 0, 1'b0);
      read_expect("r_w0_intact", 32'h8000_0000);
      read_expect("r_last", 32'h8000_3FFF);
      read_expect("r_oob_end", 32'h8000_4000);
      read_expect("r_oob_below", 32'h7FFF_FFFC);

      // W arrives 3 cycles after AW
      write_expect("w_late", 32'h8000_0020, 32'h0BAD_F00D, 8'h0F, 3, 1'b1);
      read_expect("r_late", 32'h8000_0020);

      // rready held low with a second AR pending
      a_addr = 32'h8000_0010;
      b_addr = 32'h8000_0020;
      bus.araddr = a_addr; bus.arvalid = 1'b1; bus.rready = 1'b0;
      step();
      bus.araddr = b_addr;
      k = 0;
      while (!bus.rvalid && k < LIMIT) begin step(); k++; end
      check("stall_rvalid_seen", 32'(k < LIMIT), 32'd1);
      held = bus.rdata;
      check("stall_first_data", held, model[widx(a_addr)]);
      for (int i = 0; i < 5; i++) begin
         step();
         check("stall_rvalid", 32'(bus.rvalid), 32'd1);
         check("stall_rdata", bus.rdata, held);
         check("stall_arready", 32'(bus.arready), 32'd0);
      end
      bus.rready = 1'b1;
      step();
      check("stall_release_rvalid", 32'(bus.rvalid), 32'd0);
      check("stall_release_arready", 32'(bus.arready), 32'd1);
      step();
      bus.arvalid = 1'b0;
      k = 0;
      while (!bus.rvalid && k < LIMIT) begin step(); k++; end
      check("second_ar_latency", 32'(k), 32'(LAT + 1));
      check("second_ar_data", bus.rdata, model[widx(b_addr)]);
      step();
      bus.rready = 1'b0;

      // read and write to the same word committing on the same edge
      old_val = model[widx(a_addr)];
      new_val = 32'h5A5A_A5A5;
      bus.araddr = a_addr; bus.arvalid = 1'b1; bus.rready = 1'b1;
      bus.awaddr = a_addr; bus.awvalid = 1'b1; bus.wdata = new_val; bus.wstrb = 8'h0F;
      bus.wvalid = 1'b1; bus.bready = 1'b1;
      step();
      bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      k = 0;
      while (!bus.rvalid && k < LIMIT) begin step(); k++; end
      check("coll_bvalid_same_edge", 32'(bus.bvalid), 32'd1);
      check("coll_rdata_old", bus.rdata, old_val);
      step();
      bus.rready = 1'b0; bus.bready = 1'b0;
      model[widx(a_addr)] = new_val;
      read_expect("coll_readback", a_addr);

      // reset in the middle of a read
      bus.araddr = b_addr; bus.arvalid = 1'b1; bus.rready = 1'b1;
      step();
      bus.arvalid = 1'b0;
      rst = 1'b1;
      step();
      check("midrst_rvalid", 32'(bus.rvalid), 32'd0);
      check("midrst_arready", 32'(bus.arready), 32'd0);
      rst = 1'b0;
      step();
      check("midrst_arready_back", 32'(bus.arready), 32'd1);
      check("midrst_no_resp", 32'(bus.rvalid), 32'd0);
      bus.rready = 1'b0;
      read_expect("midrst_readback", b_addr);

      // randomized mix against the model
      pool[0] = 32'd0;
      pool[1] = 32'(DEPTH - 1);
      for (int i = 2; i < 8; i++) pool[i] = $urandom_range(0, DEPTH - 1);
      for (int it = 0; it < 60; it++) begin
         sel  = $urandom_range(0, 9);
         p    = pool[$urandom_range(0, 7)];
         addr = BASE + p * 4 + $urandom_range(0, 3);
         if (sel < 2) begin
            if ($urandom_range(0, 1) == 1) oaddr = $urandom_range(0, 32'h7FFF_FFFF);
            else oaddr = 32'h8000_4000 + $urandom_range(0, 32'h0FFF_FFFF);
            if ($urandom_range(0, 1) == 1) read_expect("rnd_oob_r", oaddr);
            else write_expect("rnd_oob_w", oaddr, $urandom, 8'hFF, 0, 1'b0);
         end else if (sel < 6 || !model.exists(int'(p))) begin
            strb = model.exists(int'(p)) ? 8'($urandom) : {4'($urandom), 4'hF};
            write_expect("rnd_w", addr, $urandom, strb, $urandom_range(0, 2), 1'b0);
         end else begin
            read_expect("rnd_r", addr);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
